// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Registered grant bundle presented to the shared datapath.
    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
        logic             preempt;
    } grant_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_arbiter4_pick
    import rr_arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   enc;

    always_comb begin
        dbl = {req, req};
        rot = N_REQ'(dbl >> ptr);
        casez (rot)
            4'b???1: enc = 2'd0;
            4'b??10: enc = 2'd1;
            4'b?100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
        // Undo the rotation; wraps mod 4 by width.
        win_idx = enc + ptr;
        any     = |req;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with hold-limit preemption.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    // Saturation point of the hold counter; all-ones when the limit is disabled.
    localparam logic [CNT_W-1:0] HOLD_MAX =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

    state_e           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    grant_t           out_q, out_nxt;

    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_next;
    logic [N_REQ-1:0] others;
    logic             owner_rel;
    logic             limit;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic             pick_any;
    logic [IDX_W-1:0] win_idx;

    // While granted, the owner is masked out and the search starts just past it.
    always_comb begin
        owner      = out_q.idx;
        owner_next = IDX_W'(owner + 1'b1);
        others     = req & ~onehot(owner);
        owner_rel  = !req[owner];
        limit      = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|others);
        pick_req   = (state == ST_GRANT) ? others     : req;
        pick_ptr   = (state == ST_GRANT) ? owner_next : ptr;
    end

    rr_arbiter4_pick u_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .any     (pick_any),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            out_q    <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            out_q    <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en && pick_any) state_nxt = ST_GRANT;
            ST_GRANT: if (owner_rel && !(en && (|others))) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant, pointer and hold-counter updates in handoff/release/limit/keep priority.
    always_comb begin
        out_nxt         = out_q;
        out_nxt.preempt = 1'b0;
        ptr_nxt         = ptr;
        hold_nxt        = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (en && pick_any) begin
                    out_nxt.gnt   = onehot(win_idx);
                    out_nxt.idx   = win_idx;
                    out_nxt.valid = 1'b1;
                    hold_nxt      = '0;
                end
            end
            ST_GRANT: begin
                if (owner_rel && en && (|others)) begin
                    out_nxt.gnt   = onehot(win_idx);
                    out_nxt.idx   = win_idx;
                    out_nxt.valid = 1'b1;
                    ptr_nxt       = owner_next;
                    hold_nxt      = '0;
                end else if (owner_rel) begin
                    out_nxt.gnt   = '0;
                    out_nxt.valid = 1'b0;
                    ptr_nxt       = owner_next;
                    hold_nxt      = '0;
                end else if (limit && en) begin
                    out_nxt.gnt     = onehot(win_idx);
                    out_nxt.idx     = win_idx;
                    out_nxt.valid   = 1'b1;
                    out_nxt.preempt = 1'b1;
                    ptr_nxt         = owner_next;
                    hold_nxt        = '0;
                end else if (|others) begin
                    if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + CNT_W'(1);
                end else begin
                    hold_nxt = '0;
                end
            end
            default: begin
                out_nxt = '0;
            end
        endcase
    end

    assign gnt       = out_q.gnt;
    assign gnt_idx   = out_q.idx;
    assign gnt_valid = out_q.valid;
    assign preempt   = out_q.preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Table-driven bench for rr_arbiter4 with an expected-result queue.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       pre;
    } vec_t;

    vec_t exp_q[$];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    function automatic vec_t mk(input logic e, input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] i, input logic p);
        vec_t v;
        v.en = e; v.req = r; v.gnt = g; v.idx = i; v.pre = p;
        return v;
    endfunction

    task automatic check_now(input string name, input vec_t e);
        checks++;
        if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || preempt !== e.pre ||
            ((|e.gnt) && gnt_idx !== e.idx)) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b preempt=%b, want gnt=%b idx=%0d valid=%b preempt=%b",
                     name, gnt, gnt_idx, gnt_valid, preempt, e.gnt, e.idx, |e.gnt, e.pre);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string name, input vec_t v);
        vec_t e;
        en  = v.en;
        req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(name, e);
    endtask

    task automatic check_reset_vals(input string name);
        check_now(name, mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0));
        checks++;
        if (gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL %s_idx: got gnt_idx=%0d, want 0", name, gnt_idx);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    vec_t t_basic[2];
    vec_t t_rr[6];
    vec_t t_pre[9];
    vec_t t_en[6];

    initial begin
        t_basic[0] = mk(1, 4'b0100, 4'b0100, 2'd2, 0);
        t_basic[1] = mk(1, 4'b0000, 4'b0000, 2'd0, 0);

        t_rr[0] = mk(1, 4'b1111, 4'b0001, 2'd0, 0);
        t_rr[1] = mk(1, 4'b1110, 4'b0010, 2'd1, 0);
        t_rr[2] = mk(1, 4'b1101, 4'b0100, 2'd2, 0);
        t_rr[3] = mk(1, 4'b1011, 4'b1000, 2'd3, 0);
        t_rr[4] = mk(1, 4'b0111, 4'b0001, 2'd0, 0);
        t_rr[5] = mk(1, 4'b0000, 4'b0000, 2'd0, 0);

        t_pre[0] = mk(1, 4'b0001, 4'b0001, 2'd0, 0);
        t_pre[1] = mk(1, 4'b0101, 4'b0001, 2'd0, 0);
        t_pre[2] = mk(1, 4'b0101, 4'b0001, 2'd0, 0);
        t_pre[3] = mk(1, 4'b0101, 4'b0001, 2'd0, 0);
        t_pre[4] = mk(1, 4'b0101, 4'b0100, 2'd2, 1);
        t_pre[5] = mk(1, 4'b0101, 4'b0100, 2'd2, 0);
        t_pre[6] = mk(1, 4'b0101, 4'b0100, 2'd2, 0);
        t_pre[7] = mk(1, 4'b0101, 4'b0100, 2'd2, 0);
        t_pre[8] = mk(1, 4'b0101, 4'b0001, 2'd0, 1);

        t_en[0] = mk(1, 4'b0010, 4'b0010, 2'd1, 0);
        t_en[1] = mk(0, 4'b1010, 4'b0010, 2'd1, 0);
        t_en[2] = mk(0, 4'b1010, 4'b0010, 2'd1, 0);
        t_en[3] = mk(0, 4'b1000, 4'b0000, 2'd0, 0);
        t_en[4] = mk(0, 4'b1000, 4'b0000, 2'd0, 0);
        t_en[5] = mk(1, 4'b1000, 4'b1000, 2'd3, 0);

        do_reset();
        foreach (t_basic[i]) apply("basic", t_basic[i]);

        do_reset();
        foreach (t_rr[i]) apply("round_robin", t_rr[i]);

        do_reset();
        foreach (t_pre[i]) apply("hold_limit", t_pre[i]);

        do_reset();
        for (int i = 0; i < 50; i++) apply("single_req", mk(1, 4'b0001, 4'b0001, 2'd0, 0));

        do_reset();
        foreach (t_en[i]) apply("enable", t_en[i]);

        // Asynchronous reset in the middle of a grant, then restart from ptr=0.
        do_reset();
        apply("pre_rst_grant", mk(1, 4'b1000, 4'b1000, 2'd3, 0));
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", mk(1, 4'b1001, 4'b0001, 2'd0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
